// File: rtl/game_timer_bcd.sv
// Three-digit BCD game clock for the overlay time field: 1 s prescaler on vga_clk,
// start/stop/clear/preload control, up or down counting with a sticky expiry flag.

// One BCD digit of the counting chain; steps by one when cin is set, cout on wrap.
module game_timer_bcd_digit (
  input  logic [3:0] d,
  input  logic       cin,
  input  logic       dn,
  output logic [3:0] q,
  output logic       cout
);
  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (dn) begin
        if (d == 4'd0) begin
          q    = 4'd9;
          cout = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end else begin
        if (d >= 4'd9) begin
          q    = 4'd0;
          cout = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end
    end
  end
endmodule

module game_timer_bcd #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int PRE_W    = $clog2(CLK_FREQ)
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load_en,
  input  logic [11:0] load_value,
  input  logic        count_dn,
  output logic [3:0]  time_1s,
  output logic [3:0]  time_10s,
  output logic [3:0]  time_100s,
  output logic        running,
  output logic        sec_tick,
  output logic        expired
);
  localparam int                NDIG     = 3;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_FREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t                      state, state_nx;
  logic [PRE_W-1:0]            pre, pre_nx;
  logic [NDIG-1:0][3:0]        dig, dig_nx, dig_step;
  logic [NDIG:0]               cin;
  logic                        dir_q, dir_nx;
  logic                        tick_nx, expired_nx, load_ok;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic at_end(input logic [11:0] v, input logic dn);
    return dn ? (v == 12'h000) : (v == 12'h999);
  endfunction

  // Ripple carry/borrow chain; dig_step is the value one second later.
  assign cin[0] = 1'b1;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    game_timer_bcd_digit u_dig (
      .d    (dig[i]),
      .cin  (cin[i]),
      .dn   (dir_q),
      .q    (dig_step[i]),
      .cout (cin[i+1])
    );
  end

  always_comb begin
    state_nx   = state;
    pre_nx     = pre;
    dig_nx     = dig;
    dir_nx     = dir_q;
    tick_nx    = 1'b0;
    expired_nx = expired;
    load_ok    = load_en && (state == IDLE || state == PAUSE);
    if (clear) begin
      state_nx   = IDLE;
      pre_nx     = '0;
      dig_nx     = '0;
      expired_nx = 1'b0;
      dir_nx     = 1'b0;
    end else if (load_ok) begin
      dig_nx = {clamp9(load_value[11:8]), clamp9(load_value[7:4]), clamp9(load_value[3:0])};
      pre_nx = '0;
    end else if (stop && state == RUN) begin
      state_nx = PAUSE;
    end else if (start && (state == IDLE || state == PAUSE)) begin
      // Resuming from PAUSE keeps direction and the partial second.
      if (state == IDLE) begin
        dir_nx = count_dn;
        pre_nx = '0;
      end
      if (at_end(dig, dir_nx)) begin
        state_nx   = DONE;
        expired_nx = 1'b1;
      end else begin
        state_nx = RUN;
      end
    end else if (state == RUN) begin
      if (pre == PRE_LAST) begin
        pre_nx  = '0;
        tick_nx = 1'b1;
        dig_nx  = cin[NDIG] ? dig : dig_step;
        if (at_end(dig_nx, dir_q)) begin
          state_nx   = DONE;
          expired_nx = 1'b1;
        end
      end else begin
        pre_nx = pre + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      pre      <= '0;
      dig      <= '0;
      dir_q    <= 1'b0;
      running  <= 1'b0;
      sec_tick <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nx;
      pre      <= pre_nx;
      dig      <= dig_nx;
      dir_q    <= dir_nx;
      running  <= (state_nx == RUN);
      sec_tick <= tick_nx;
      expired  <= expired_nx;
    end
  end

  assign time_1s   = dig[0];
  assign time_10s  = dig[1];
  assign time_100s = dig[2];
endmodule

// File: tb/tb_game_timer_bcd.sv
// Bench for game_timer_bcd: directed test-plan scenarios plus random commands,
// all compared each cycle against an integer-valued reference model.
module tb_game_timer_bcd;
  localparam int F = 10;

  logic        vga_clk = 1'b0, sys_rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load_en = 1'b0, count_dn = 1'b0;
  logic [11:0] load_value = '0;
  logic [3:0]  time_1s, time_10s, time_100s;
  logic        running, sec_tick, expired;

  game_timer_bcd #(.CLK_FREQ(F)) dut (
    .vga_clk    (vga_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .load_en    (load_en),
    .load_value (load_value),
    .count_dn   (count_dn),
    .time_1s    (time_1s),
    .time_10s   (time_10s),
    .time_100s  (time_100s),
    .running    (running),
    .sec_tick   (sec_tick),
    .expired    (expired)
  );

  always #5 vga_clk = ~vga_clk;

  int n_chk = 0, n_fail = 0, cnt = 0;
  // Model: time as a plain integer, mode 0 idle / 1 run / 2 pause / 3 done.
  int m_val, m_mode, m_pre;
  bit m_dn, m_tick, m_exp;
  int tick_q[$];

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [11:0] x);
    int h, t, u;
    h = (x[11:8] > 4'd9) ? 9 : int'(x[11:8]);
    t = (x[7:4]  > 4'd9) ? 9 : int'(x[7:4]);
    u = (x[3:0]  > 4'd9) ? 9 : int'(x[3:0]);
    return h * 100 + t * 10 + u;
  endfunction

  function automatic bit is_end(input int v, input bit dn);
    return dn ? (v == 0) : (v == 999);
  endfunction

  task automatic model_reset();
    m_val = 0; m_mode = 0; m_pre = 0; m_dn = 0; m_tick = 0; m_exp = 0;
  endtask

  task automatic model_step();
    m_tick = 0;
    if (clear) begin
      m_mode = 0; m_val = 0; m_pre = 0; m_exp = 0; m_dn = 0;
    end else if (load_en && (m_mode == 0 || m_mode == 2)) begin
      m_val = clamp_val(load_value);
      m_pre = 0;
    end else if (stop && m_mode == 1) begin
      m_mode = 2;
    end else if (start && (m_mode == 0 || m_mode == 2)) begin
      if (m_mode == 0) begin
        m_dn  = count_dn;
        m_pre = 0;
      end
      if (is_end(m_val, m_dn)) begin
        m_mode = 3; m_exp = 1;
      end else begin
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (m_pre == F - 1) begin
        m_pre  = 0;
        m_tick = 1;
        m_val  = m_dn ? m_val - 1 : m_val + 1;
        if (is_end(m_val, m_dn)) begin
          m_mode = 3; m_exp = 1;
        end
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic check_model();
    check("digits",   {4'h0, time_100s, time_10s, time_1s}, {4'h0, to_bcd(m_val)});
    check("running",  running,  m_mode == 1);
    check("sec_tick", sec_tick, m_tick);
    check("expired",  expired,  m_exp);
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic cyc(input logic st, input logic sp, input logic cl, input logic ld,
                     input logic [11:0] lv, input logic dn);
    start = st; stop = sp; clear = cl; load_en = ld; load_value = lv; count_dn = dn;
    @(posedge vga_clk);
    model_step();
    @(negedge vga_clk);
    start = 0; stop = 0; clear = 0; load_en = 0;
    cnt++;
    check_model();
    if (sec_tick) tick_q.push_back(cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 12'h000, 0);
  endtask

  task automatic do_start(input logic dn); cyc(1, 0, 0, 0, 12'h000, dn); endtask
  task automatic do_stop();  cyc(0, 1, 0, 0, 12'h000, 0); endtask
  task automatic do_clear(); cyc(0, 0, 1, 0, 12'h000, 0); endtask
  task automatic do_load(input logic [11:0] v); cyc(0, 0, 0, 1, v, 0); endtask

  initial begin
    int t0, bad;
    model_reset();
    #1;
    check("rst_digits",  {time_100s, time_10s, time_1s}, 12'h000);
    check("rst_running", running, 1'b0);
    check("rst_tick",    sec_tick, 1'b0);
    check("rst_expired", expired, 1'b0);
    repeat (2) @(negedge vga_clk);
    sys_rst_n = 1'b1;
    idle(3);

    // Up count, 125 ticks
    do_clear();
    tick_q.delete();
    t0 = cnt;
    do_start(0);
    idle(1250);
    check("up_ticks", 16'(tick_q.size()), 16'd125);
    if (tick_q.size() > 0) check("up_first", 16'(tick_q[0] - t0), 16'd11);
    bad = 0;
    for (int i = 1; i < tick_q.size(); i++) if (tick_q[i] - tick_q[i-1] != F) bad++;
    check("up_gaps", 16'(bad), 16'd0);
    check("up_125", {4'h0, time_100s, time_10s, time_1s}, 16'h0125);

    // Saturation at 999
    do_clear();
    do_load(12'h998);
    do_start(0);
    idle(25);
    check("sat_digits",  {time_100s, time_10s, time_1s}, 12'h999);
    check("sat_expired", expired, 1'b1);
    check("sat_running", running, 1'b0);
    idle(50);
    check("sat_hold", {time_100s, time_10s, time_1s}, 12'h999);

    // Down count from 100
    do_clear();
    do_load(12'h100);
    do_start(1);
    idle(10);
    check("dn_first_tick", sec_tick, 1'b1);
    check("dn_099", {time_100s, time_10s, time_1s}, 12'h099);
    idle(990);
    check("dn_end_digits",  {time_100s, time_10s, time_1s}, 12'h000);
    check("dn_end_tick",    sec_tick, 1'b1);
    check("dn_end_expired", expired, 1'b1);

    // Start already at terminal value
    do_clear();
    do_load(12'h000);
    do_start(1);
    check("zero_expired", expired, 1'b1);
    check("zero_running", running, 1'b0);
    check("zero_notick",  sec_tick, 1'b0);

    // Pause at prescaler 4, resume
    do_clear();
    do_start(0);
    idle(4);
    do_stop();
    idle(30);
    check("pause_digits",  {time_100s, time_10s, time_1s}, 12'h000);
    check("pause_running", running, 1'b0);
    tick_q.delete();
    t0 = cnt;
    do_start(0);
    for (int i = 0; i < 20 && tick_q.size() == 0; i++) idle(1);
    if (tick_q.size() == 0) check("resume_tick_seen", 1'b0, 1'b1);
    else check("resume_gap", 16'(tick_q[0] - t0), 16'd7);

    // Command collisions and limits
    do_clear();
    do_load(12'h300);
    do_start(0);
    idle(3);
    cyc(1, 0, 1, 1, 12'h777, 0);
    check("coll_running", running, 1'b0);
    check("coll_digits",  {time_100s, time_10s, time_1s}, 12'h000);
    do_start(0);
    idle(2);
    cyc(0, 0, 0, 1, 12'h555, 0);
    check("run_load_ign", {time_100s, time_10s, time_1s}, 12'h000);
    check("run_load_run", running, 1'b1);
    do_clear();
    do_load(12'hFAB);
    check("clamp", {time_100s, time_10s, time_1s}, 12'h999);

    // Asynchronous reset mid-run
    do_clear();
    do_load(12'h040);
    do_start(0);
    idle(20);
    check("pre_rst_digits", {time_100s, time_10s, time_1s}, 12'h042);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_digits",  {time_100s, time_10s, time_1s}, 12'h000);
    check("arst_running", running, 1'b0);
    check("arst_expired", expired, 1'b0);
    model_reset();
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    idle(20);
    check("post_rst_running", running, 1'b0);

    // Random command mix
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 63) == 0,
          $urandom_range(0, 23) == 0, 12'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/game_timer_bcd.md
# game_timer_bcd

Elapsed/remaining game-time counter producing three BCD digits (hundreds, tens, units of seconds) for the on-screen time field drawn by the border/overlay pixel stage. It runs on vga_clk. A prescaler divides vga_clk down to a 1 s tick. A small control FSM handles start, pause, clear and preload, counting either up or down. Its digit outputs drive the overlay's time_100s/time_10s/time_1s inputs directly.

## Interface

Parameters:
- CLK_FREQ, 25_000_000, vga_clk cycles per second; prescaler terminal count is CLK_FREQ-1.
- PRE_W, $clog2(CLK_FREQ), prescaler width.

Ports:
- vga_clk  in  1  pixel clock; all state on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin or resume counting.
- stop  in  1  one-cycle pulse; pause counting.
- clear  in  1  one-cycle pulse; return to IDLE.
- load_en  in  1  one-cycle pulse; preload digits from load_value.
- load_value  in  12  BCD preload, [11:8] hundreds, [7:4] tens, [3:0] units.
- count_dn  in  1  direction: 1 = down, 0 = up; sampled only when RUN is entered from IDLE.
- time_1s  out  4  units digit, BCD 0–9.
- time_10s  out  4  tens digit, BCD 0–9.
- time_100s  out  4  hundreds digit, BCD 0–9.
- running  out  1  high while state is RUN.
- sec_tick  out  1  one-cycle pulse coincident with each digit update.
- expired  out  1  sticky; high in DONE.

## Operation

- Registered state: FSM state, prescaler, digits, the latched direction bit dir_q, and all outputs. No combinational output paths.
- FSM states and transitions:
  - IDLE → RUN on start.
  - RUN → PAUSE on stop.
  - PAUSE → RUN on start.
  - RUN → DONE on terminal count.
  - Any state → IDLE on clear.
  - DONE ignores start and stop.
- Command priority when pulses coincide: clear > load_en > stop > start.
- clear:
  - Digits ← 000, prescaler ← 0, expired ← 0, dir_q ← 0.
  - Next state IDLE.
- load_en:
  - Accepted only in IDLE or PAUSE; ignored in RUN and DONE.
  - Digits ← load_value, with each nibble > 9 clamped to 9.
  - Prescaler ← 0. State unchanged.
- start:
  - From IDLE: dir_q ← count_dn, prescaler ← 0.
  - From PAUSE: prescaler and dir_q are retained, so a partial second resumes.
- Prescaler:
  - Increments only in RUN.
  - At CLK_FREQ-1 it wraps to 0 and generates the tick.
- Up-count on tick:
  - Units 9→0 carries into tens; tens 9→0 carries into hundreds.
  - Reaching 999 enters DONE with expired = 1.
  - Digits hold at 999; no wrap to 000.
- Down-count on tick:
  - Units 0→9 borrows from tens; tens 0→9 borrows from hundreds.
  - Reaching 000 enters DONE with expired = 1.
- Start edge cases:
  - Start from IDLE with digits already at the terminal value (000 down, or 999 up) goes to DONE on the next cycle.
  - In that case expired = 1 and no tick is generated.
- Digits are always valid BCD; no nibble ever exceeds 9.

## Timing

- Reset values, asynchronous:
  - State IDLE; prescaler 0; dir_q 0.
  - time_1s / time_10s / time_100s = 0.
  - running = 0, sec_tick = 0, expired = 0.
- start pulse in cycle N (from IDLE): running = 1 from cycle N+1. The prescaler counts 0 in N+1.
- First tick:
  - The prescaler reaches CLK_FREQ-1 in cycle N+CLK_FREQ.
  - sec_tick is high and the digits show the new value in cycle N+CLK_FREQ+1.
  - Tick period is exactly CLK_FREQ cycles while in RUN.
- stop in cycle M: running = 0 from M+1. The prescaler freezes at its value from cycle M.
- Terminal tick: digits update, sec_tick = 1, expired = 1 and running = 0 all in the same cycle.
- Commands and digits:
  - load_en / clear in cycle K: digits change in K+1.
  - A tick falling due in the same cycle as clear or stop is suppressed.
- Asserting reset mid-count returns everything to reset values immediately. Counting does not restart until a new start.

## Test plan

- Up-count, CLK_FREQ=10:
  - Stimulus: start, run 125 ticks.
  - Required: digits 1/2/5; sec_tick pulses exactly every 10 cycles; first pulse 11 cycles after start.
- Up-count saturation:
  - Stimulus: load 0x998, start, wait 2 ticks.
  - Required: digits 999, expired = 1, running = 0; digits stay 999 for 50 further cycles.
- Down-count:
  - Stimulus: load 0x100, count_dn = 1, start.
  - Required: first tick gives 099; terminal count gives 000 with expired = 1.
  - Also: start with load 0x000 gives DONE one cycle later with no tick.
- Pause/resume:
  - Stimulus: stop at prescaler = 4, wait 30 cycles, start.
  - Required: next tick arrives 6 cycles after resume (+1); digits unchanged during pause.
- Command collisions and limits:
  - Stimulus: clear + load_en + start in the same cycle.
  - Required: IDLE with digits 000.
  - Stimulus: load_en during RUN. Required: ignored.
  - Stimulus: load 0xFAB. Required: clamps to 999.
- Reset mid-run:
  - Stimulus: assert sys_rst_n = 0 asynchronously at digits 042.
  - Required: all outputs 0 before the next clock edge; still IDLE after release.
